pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It drives freeze/flush for the PC, IF/ID and ID/EX registers, and a global freeze for the whole pipeline.
- Detects RAW/load-use hazards from ID source registers against EXE/MEM destinations.
- Applies branch flushes.
- Stalls the pipeline while the multi-cycle data memory is busy, with a timeout watchdog.

Parameters:
REG_W, 4, register-address width
TIMEOUT, 64, max cycles in MEM_WAIT before abort (>=2)
CNT_W, 32, width of performance counters (optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
fwd_en  in  1  forwarding unit enabled
id_src1  in  REG_W  ID-stage source 1
id_src2  in  REG_W  ID-stage source 2
id_use_src1  in  1  ID instruction reads src1
id_use_src2  in  1  ID instruction reads src2
exe_wb_en  in  1  EXE instruction writes a register
exe_dest  in  REG_W  EXE destination
exe_mem_read  in  1  EXE instruction is a load
mem_wb_en  in  1  MEM instruction writes a register
mem_dest  in  REG_W  MEM destination
branch_taken  in  1  EXE resolved taken branch
mem_access  in  1  MEM stage holds load/store (level)
mem_ready  in  1  data memory completes access this cycle
pc_freeze  out  1  hold PC
ifid_freeze  out  1  hold IF/ID
ifid_flush  out  1  clear IF/ID
idex_flush  out  1  insert bubble into ID/EX
global_freeze  out  1  hold all pipeline registers, PC and RF writes
mem_err  out  1  sticky memory-timeout flag
stall_cycles  out  CNT_W  perf counter (optional feature)
flush_count  out  CNT_W  perf counter (optional feature)

Behaviour:
- FSM states: RUN, MEM_WAIT. Reset state: RUN; timeout counter = 0; mem_err = 0; counters = 0.
- While rst is high, all outputs are 0.
- Data hazard (combinational):
  - fwd_en=1: hazard = exe_mem_read & exe_wb_en & ((id_use_src1 & id_src1==exe_dest) | (id_use_src2 & id_src2==exe_dest)).
  - fwd_en=0: hazard = any used source matching exe_dest (exe_wb_en) or mem_dest (mem_wb_en).
  - No reserved/zero register exemption.
- Memory-wait entry, in RUN:
  - If mem_access & ~mem_ready: global_freeze=1 this cycle (combinational); next state MEM_WAIT; timeout counter loads 1.
  - If mem_access & mem_ready in the same cycle: no stall, stay in RUN.
- In MEM_WAIT:
  - global_freeze = ~mem_ready. The counter increments every cycle without ready.
  - mem_ready=1: global_freeze=0 that cycle, return to RUN, counter cleared.
  - Counter reaches TIMEOUT without ready: mem_err set (sticky until rst), global_freeze=0 that cycle, return to RUN.
- Priority per cycle: global_freeze > branch_taken > hazard.
  - While global_freeze=1, pc_freeze/ifid_freeze/ifid_flush/idex_flush are all 0. The frozen pipeline keeps branch_taken/hazard inputs stable, so they take effect on the release cycle.
  - branch_taken=1: ifid_flush=1, idex_flush=1, pc_freeze=0, ifid_freeze=0. This holds even if a hazard is present, because the ID instruction is wrong-path.
  - hazard (no branch): pc_freeze=1, ifid_freeze=1, idex_flush=1, ifid_flush=0. It lasts as long as the hazard persists: 1 cycle for a forwarded load-use, up to 2 cycles when forwarding is off.
- All outputs except mem_err and the counters are combinational from inputs + state. Zero added latency.
- rst mid-MEM_WAIT: immediate return to RUN, all outputs cleared.

Optional Feature:
- PIPE_PERF_CNT_EN defined:
  - stall_cycles increments every cycle global_freeze | pc_freeze is 1.
  - flush_count increments every cycle ifid_flush is 1.
  - Both wrap at 2^CNT_W and clear on rst.
- Undefined: both ports tied to 0, no counter flops.

Decomposition:
- Package pipe_ctrl_pkg: FSM state enum (RUN, MEM_WAIT), default REG_W/TIMEOUT constants.
- One sub-module hazard_detect: purely combinational hazard equation. FSM, priority and counters stay in the top.

Test Plan:
- fwd_en=1, exe load dest=3, id_src1=3 used -> 1 cycle pc_freeze=ifid_freeze=idex_flush=1, then all 0.
- fwd_en=0, mem_dest=5 wb, id_src2=5 used -> hazard asserted that cycle; exe_dest=5 -> asserted 2 consecutive cycles.
- branch_taken=1 together with load-use hazard -> ifid_flush=idex_flush=1, pc_freeze=0.
- mem_access=1, mem_ready low 3 cycles then high -> global_freeze high 3 cycles, low on ready cycle, state RUN; with PIPE_PERF_CNT_EN stall_cycles=3.
- mem_access=1, ready never, TIMEOUT=4 -> global_freeze for 4 cycles, mem_err=1 thereafter until rst.
- rst asserted during MEM_WAIT -> outputs 0 immediately, mem_err=0, next access re-enters MEM_WAIT normally.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default sizing for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int DEF_REG_W   = 4;
  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_CNT_W   = 32;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-to-sequencer signal bundle; the pipeline is the master, the sequencer the slave.
interface pipeline_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = DEF_REG_W,
  parameter int CNT_W = DEF_CNT_W
);
  logic             fwd_en;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_use_src1;
  logic             id_use_src2;
  logic             exe_wb_en;
  logic [REG_W-1:0] exe_dest;
  logic             exe_mem_read;
  logic             mem_wb_en;
  logic [REG_W-1:0] mem_dest;
  logic             branch_taken;
  logic             mem_access;
  logic             mem_ready;

  logic             pc_freeze;
  logic             ifid_freeze;
  logic             ifid_flush;
  logic             idex_flush;
  logic             global_freeze;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output fwd_en, id_src1, id_src2, id_use_src1, id_use_src2,
           exe_wb_en, exe_dest, exe_mem_read, mem_wb_en, mem_dest,
           branch_taken, mem_access, mem_ready,
    input  pc_freeze, ifid_freeze, ifid_flush, idex_flush,
           global_freeze, mem_err, stall_cycles, flush_count
  );

  modport slave (
    input  fwd_en, id_src1, id_src2, id_use_src1, id_use_src2,
           exe_wb_en, exe_dest, exe_mem_read, mem_wb_en, mem_dest,
           branch_taken, mem_access, mem_ready,
    output pc_freeze, ifid_freeze, ifid_flush, idex_flush,
           global_freeze, mem_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_detect.sv
// Combinational RAW / load-use detector: ID sources against EXE and MEM destinations.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = DEF_REG_W
) (
  input  logic             fwd_en,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic             exe_wb_en,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_mem_read,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  output logic             hazard
);
  logic [1:0]       src_used;
  logic [REG_W-1:0] src [2];
  logic [1:0]       exe_hit;
  logic [1:0]       mem_hit;

  assign src_used = {id_use_src2, id_use_src1};
  assign src[0]   = id_src1;
  assign src[1]   = id_src2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign exe_hit[gi] = src_used[gi] & exe_wb_en & (src[gi] == exe_dest);
      assign mem_hit[gi] = src_used[gi] & mem_wb_en & (src[gi] == mem_dest);
    end
  endgenerate

  // With forwarding only a load in EXE cannot be bypassed; without it any in-flight writer blocks.
  assign hazard = fwd_en ? (exe_mem_read & (|exe_hit)) : ((|exe_hit) | (|mem_hit));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline sequencer: hazard stalls, branch flushes, data-memory wait with watchdog.
// Optional perf counters (stall_cycles, flush_count) enabled by defining PIPE_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W   = DEF_REG_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_e           state_reg, state_next;
  logic [TMO_W-1:0] tmo_reg, tmo_next;
  logic             err_reg, err_next;
  logic             freeze;
  logic             hazard;
  logic             gf, br, hz;

  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .fwd_en       (bus.fwd_en),
    .id_src1      (bus.id_src1),
    .id_src2      (bus.id_src2),
    .id_use_src1  (bus.id_use_src1),
    .id_use_src2  (bus.id_use_src2),
    .exe_wb_en    (bus.exe_wb_en),
    .exe_dest     (bus.exe_dest),
    .exe_mem_read (bus.exe_mem_read),
    .mem_wb_en    (bus.mem_wb_en),
    .mem_dest     (bus.mem_dest),
    .hazard       (hazard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
      tmo_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      tmo_reg   <= tmo_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tmo_next   = tmo_reg;
    err_next   = err_reg;
    freeze     = 1'b0;
    case (state_reg)
      RUN: begin
        if (bus.mem_access && !bus.mem_ready) begin
          freeze     = 1'b1;
          state_next = MEM_WAIT;
          tmo_next   = TMO_W'(1);
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_next = RUN;
          tmo_next   = '0;
        end else if (tmo_reg == TMO_W'(TIMEOUT)) begin
          // Watchdog abort: release the pipeline and latch the error.
          err_next   = 1'b1;
          state_next = RUN;
          tmo_next   = '0;
        end else begin
          freeze   = 1'b1;
          tmo_next = tmo_reg + 1'b1;
        end
      end
      default: begin
        state_next = RUN;
        tmo_next   = '0;
      end
    endcase
  end

  // Freeze outranks branch, branch outranks hazard; everything is masked during reset.
  assign gf = ~rst & freeze;
  assign br = ~rst & ~freeze & bus.branch_taken;
  assign hz = ~rst & ~freeze & ~bus.branch_taken & hazard;

  assign bus.global_freeze = gf;
  assign bus.pc_freeze     = hz;
  assign bus.ifid_freeze   = hz;
  assign bus.ifid_flush    = br;
  assign bus.idex_flush    = br | hz;
  assign bus.mem_err       = err_reg;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_reg;
  logic [CNT_W-1:0] flush_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_reg <= '0;
      flush_reg <= '0;
    end else begin
      if (gf | hz) stall_reg <= stall_reg + 1'b1;
      if (br)      flush_reg <= flush_reg + 1'b1;
    end
  end

  assign bus.stall_cycles = stall_reg;
  assign bus.flush_count  = flush_reg;
`else
  assign bus.stall_cycles = {CNT_W{1'b0}};
  assign bus.flush_count  = {CNT_W{1'b0}};
`endif
endmodule
